board_io_shell: RTL and testbench

Parametrised board-level front end that sits between the DE-board pins and the solver core. It converts the active-low push-button reset into a clean core reset and synchronises and debounces an arbitrary number of slide switches, producing level and rising-edge outputs. It also drives any number of seven-segment digits from a packed hex value, with leading-zero blanking and blink.

---
 rtl/board_io_pkg.sv | 20 ++
 rtl/board_io_shell_if.sv | 22 ++
 rtl/board_io_shell_sw_debounce.sv | 50 +++++
 rtl/board_io_shell.sv | 89 ++++++++
 tb/tb_board_io_shell.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared constants, glyph decode and width helper for board_io_shell
package board_io_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba glyphs for 0-F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_io_shell_if.sv
// rtl/board_io_shell_if.sv - display request bundle between core and board_io_shell
interface board_io_shell_if #(
  parameter int NUM_HEX = 6
);

  logic [4*NUM_HEX-1:0] disp_value;
  logic                 disp_blank_lz;
  logic                 disp_blink;

  modport master (
    output disp_value,
    output disp_blank_lz,
    output disp_blink
  );

  modport slave (
    input disp_value,
    input disp_blank_lz,
    input disp_blink
  );

endinterface

// File: rtl/board_io_shell_sw_debounce.sv
// rtl/board_io_shell_sw_debounce.sv - one-bit switch synchroniser, debouncer and rise detector
module sw_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_async,
  output logic level,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sw_async;
      sync_q2 <= sync_q1;
    end
  end

  // Counter reaches DEBOUNCE_CYCLES after that many differing cycles; the level moves on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        cnt   <= '0;
        level <= sync_q2;
        rise  <= sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io_shell.sv
// rtl/board_io_shell.sv - reset bridge, debounced switches and blinking seven-segment display
module board_io_shell
  import board_io_pkg::*;
#(
  parameter int NUM_SW          = 2,
  parameter int NUM_HEX         = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF      = 25000000
) (
  input  logic                 CLOCK_50,
  input  logic                 nrst,
  input  logic [NUM_SW-1:0]    SW,
  output logic                 rst,
  output logic [NUM_SW-1:0]    sw_level,
  output logic [NUM_SW-1:0]    sw_rise,
  board_io_shell_if.slave      disp,
  output logic [7*NUM_HEX-1:0] HEX
);

  localparam int BL_W = cnt_width(BLINK_HALF);

  logic            rst_q1;
  logic            blink_off;
  logic [BL_W-1:0] blink_cnt;
  logic [7*NUM_HEX-1:0] hex_next;

  always_ff @(posedge CLOCK_50 or negedge nrst) begin
    if (!nrst) begin
      rst_q1 <= 1'b1;
      rst    <= 1'b1;
    end else begin
      rst_q1 <= 1'b0;
      rst    <= rst_q1;
    end
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
      .clk      (CLOCK_50),
      .rst_n    (nrst),
      .sw_async (SW[g]),
      .level    (sw_level[g]),
      .rise     (sw_rise[g])
    );
  end

  // Free-running even when blink is disabled, so enabling it joins the shared phase
  always_ff @(posedge CLOCK_50 or negedge nrst) begin
    if (!nrst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    logic       seen;
    logic [3:0] nib;
    hex_next = '1;
    seen     = 1'b0;
    nib      = 4'h0;
    for (int i = NUM_HEX - 1; i >= 0; i--) begin
      nib  = disp.disp_value[4*i +: 4];
      seen = seen | (nib != 4'h0) | (i == 0);
      if (disp.disp_blink && blink_off) begin
        hex_next[7*i +: 7] = SEG_BLANK;
      end else if (disp.disp_blank_lz && !seen) begin
        hex_next[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_next[7*i +: 7] = hex_to_seg(nib);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nrst) begin
    if (!nrst) begin
      HEX <= '1;
    end else begin
      HEX <= hex_next;
    end
  end

endmodule

// File: tb/tb_board_io_shell.sv
// tb/tb_board_io_shell.sv - directed self-checking bench for board_io_shell
module tb_board_io_shell;

  localparam logic [41:0] H_BLANK  = {6{7'h7F}};
  localparam logic [41:0] H_A30    = {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h30, 7'h40};
  localparam logic [41:0] H_Z_LZ   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [41:0] H_Z_ALL  = {6{7'h40}};
  localparam logic [41:0] H_123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] H_0F0000 = {7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [41:0] H_FEDCB9 = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h10};

  logic        clk;
  logic        nrst;
  logic [1:0]  SW;
  logic        rst;
  logic [1:0]  sw_level;
  logic [1:0]  sw_rise;
  logic [41:0] HEX;
  logic        saw_rise;

  int n_pass;
  int n_total;

  board_io_shell_if #(.NUM_HEX(6)) disp_if ();

  board_io_shell #(
    .NUM_SW          (2),
    .NUM_HEX         (6),
    .DEBOUNCE_CYCLES (4),
    .BLINK_HALF      (8)
  ) dut (
    .CLOCK_50 (clk),
    .nrst     (nrst),
    .SW       (SW),
    .rst      (rst),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .disp     (disp_if),
    .HEX      (HEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    nrst    = 1'b0;
    SW      = 2'b00;
    disp_if.disp_value    = '0;
    disp_if.disp_blank_lz = 1'b0;
    disp_if.disp_blink    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_rst", rst, 1);
    check("reset_hex", HEX, H_BLANK);
    check("reset_level", sw_level, 0);
    check("reset_rise", sw_rise, 0);

    nrst = 1'b1;
    @(negedge clk);
    check("rst_edge1", rst, 1);
    @(negedge clk);
    check("rst_edge2", rst, 0);

    // clean edge on SW[0]
    SW[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("clean_before", sw_level, 2'b00);
    @(negedge clk);
    check("clean_level", sw_level, 2'b01);
    check("clean_rise", sw_rise, 2'b01);
    @(negedge clk);
    check("clean_rise_end", sw_rise, 2'b00);
    check("clean_hold", sw_level, 2'b01);

    // 3-cycle bounce on SW[1] must be rejected
    SW[1] = 1'b1;
    repeat (3) @(negedge clk);
    SW[1] = 1'b0;
    saw_rise = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw_rise |= sw_rise[1];
    end
    check("bounce_level", sw_level, 2'b01);
    check("bounce_rise", saw_rise, 0);

    SW[1] = 1'b1;
    repeat (6) @(negedge clk);
    check("hold_before", sw_level, 2'b01);
    @(negedge clk);
    check("hold_level", sw_level, 2'b11);
    check("hold_rise", sw_rise, 2'b10);

    // display patterns
    disp_if.disp_value    = 24'h000A30;
    disp_if.disp_blank_lz = 1'b1;
    @(negedge clk);
    check("disp_a30_lz", HEX, H_A30);
    disp_if.disp_value = 24'h000000;
    @(negedge clk);
    check("disp_zero_lz", HEX, H_Z_LZ);
    disp_if.disp_blank_lz = 1'b0;
    @(negedge clk);
    check("disp_zero_all", HEX, H_Z_ALL);
    disp_if.disp_value = 24'h123456;
    @(negedge clk);
    check("disp_123456", HEX, H_123456);
    disp_if.disp_value    = 24'h0F0000;
    disp_if.disp_blank_lz = 1'b1;
    @(negedge clk);
    check("disp_0f0000_lz", HEX, H_0F0000);
    disp_if.disp_value = 24'hFEDCB9;
    @(negedge clk);
    check("disp_fedcb9_lz", HEX, H_FEDCB9);

    // blink, then reset mid-count with both switches held high
    disp_if.disp_value    = 24'h123456;
    disp_if.disp_blank_lz = 1'b0;
    disp_if.disp_blink    = 1'b1;
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mid_rst_hex", HEX, H_BLANK);
    check("mid_rst_rst", rst, 1);
    check("mid_rst_level", sw_level, 2'b00);
    @(negedge clk);
    check("mid_rst_hold", HEX, H_BLANK);
    nrst = 1'b1;

    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      check($sformatf("blink_e%0d", n), HEX, (((n - 1) / 8) % 2 == 0) ? H_123456 : H_BLANK);
      if (n == 1) check("exit_rst1", rst, 1);
      if (n == 2) check("exit_rst2", rst, 0);
      if (n == 6) check("exit_level_before", sw_level, 2'b00);
      if (n == 7) begin
        check("exit_level", sw_level, 2'b11);
        check("exit_rise", sw_rise, 2'b11);
      end
      if (n == 8) check("exit_rise_end", sw_rise, 2'b00);
      if (n < 7) check($sformatf("exit_norise_e%0d", n), sw_rise, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
